// File: rtl/cpu7_ifu_inst_enc.sv
// Purpose : instruction-word assembler (inverse of IFU immediate/offset extraction);
//           range-checks an immediate or byte offset and packs it into LoongArch fields.
// Latency : 1 cycle through a single output register; 1 word/cycle back-to-back.
// Backpressure: req_ready = !out_valid | out_ready; a held word stays stable.
// Ports   : clk/resetn (async active-low); req_* request with valid/ready;
//           out_valid/out_ready/out_inst/out_err result; cnt_ok/cnt_err saturating
//           counts of delivered words without/with error.
module cpu7_ifu_inst_enc #(
  parameter int GRLEN = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_opc,
  input  logic [3:0]       req_fmt,
  input  logic             req_unsign,
  input  logic [2:0]       req_shift,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rj,
  input  logic [4:0]       req_rk,
  input  logic [GRLEN-1:0] req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  localparam logic [31:0] BREAK0 = 32'h002A0000;

  // Signed fit: everything from the field's sign bit upward must be a sign extension.
  function automatic logic fit_s(input logic [31:0] v, input int unsigned w);
    logic [31:0] hi;
    hi = $signed(v) >>> (w - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  function automatic logic fit_u(input logic [31:0] v, input int unsigned w);
    return (v >> w) == '0;
  endfunction

  logic [31:0]        w_imm;
  logic signed [31:0] w_imm_s;
  logic [4:0]         w_sh;
  logic               w_sh_bad;
  logic               w_i_bad;
  logic [31:0]        w_f;
  logic [31:0]        w_off;
  logic               w_off_bad;
  logic [31:0]        w_word;
  logic               w_err;
  logic               w_accept;
  logic               w_drain;

  logic               r_vld;
  logic [31:0]        r_inst;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt_ok;
  logic [CNT_W-1:0]   r_cnt_err;

  assign w_imm   = req_imm;
  assign w_imm_s = req_imm;

  always_comb begin
    w_sh     = 5'd0;
    w_sh_bad = 1'b0;
    case (req_shift)
      3'd0:    w_sh = 5'd0;
      3'd1:    w_sh = 5'd2;
      3'd2:    w_sh = 5'd12;
      3'd3:    w_sh = 5'd16;
      3'd4:    w_sh = 5'd18;
      default: w_sh_bad = 1'b1;
    endcase

    // Field value is the arithmetic right shift; any bit shifted out must be zero.
    w_f       = w_imm_s >>> w_sh;
    w_i_bad   = w_sh_bad | ((w_imm & ((32'd1 << w_sh) - 32'd1)) != '0);
    w_off     = w_imm_s >>> 2;
    w_off_bad = (w_imm[1:0] != 2'b00);

    w_word      = req_opc;
    w_word[4:0] = req_rd;
    w_word[9:5] = req_rj;
    w_err       = 1'b0;

    case (req_fmt)
      4'd0: w_word[14:10] = req_rk;
      4'd1: begin
        w_word[14:10] = w_f[4:0];
        w_err = w_i_bad | !(req_unsign ? fit_u(w_f, 5) : fit_s(w_f, 5));
      end
      4'd2: begin
        w_word[15:10] = w_f[5:0];
        w_err = w_i_bad | !(req_unsign ? fit_u(w_f, 6) : fit_s(w_f, 6));
      end
      4'd3: begin
        w_word[21:10] = w_f[11:0];
        w_err = w_i_bad | !(req_unsign ? fit_u(w_f, 12) : fit_s(w_f, 12));
      end
      4'd4: begin
        w_word[23:10] = w_f[13:0];
        w_err = w_i_bad | !fit_s(w_f, 14);
      end
      4'd5: begin
        w_word[25:10] = w_f[15:0];
        w_err = w_i_bad | !fit_s(w_f, 16);
      end
      4'd6: begin
        // 20-bit immediate occupies the rj slot as well.
        w_word[24:5] = w_f[19:0];
        w_err = w_i_bad | !fit_s(w_f, 20);
      end
      4'd7: begin
        w_word[25:10] = w_off[15:0];
        w_err = w_off_bad | !fit_s(w_off, 16);
      end
      4'd8: begin
        w_word[25:10] = w_off[15:0];
        w_word[4:0]   = w_off[20:16];
        w_err = w_off_bad | !fit_s(w_off, 21);
      end
      4'd9: begin
        w_word[25:10] = w_off[15:0];
        w_word[9:0]   = w_off[25:16];
        w_err = w_off_bad | !fit_s(w_off, 26);
      end
      default: w_err = 1'b1;
    endcase
  end

  assign req_ready = !r_vld | out_ready;
  assign w_accept  = req_valid & req_ready;
  assign w_drain   = r_vld & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld  <= 1'b0;
      r_inst <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_vld  <= 1'b1;
      r_inst <= w_err ? BREAK0 : w_word;
      r_err  <= w_err;
    end else if (w_drain) begin
      r_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt_ok  <= '0;
      r_cnt_err <= '0;
    end else if (w_drain) begin
      if (r_err) begin
        if (r_cnt_err != '1) r_cnt_err <= r_cnt_err + 1'b1;
      end else begin
        if (r_cnt_ok != '1) r_cnt_ok <= r_cnt_ok + 1'b1;
      end
    end
  end

  assign out_valid = r_vld;
  assign out_inst  = r_inst;
  assign out_err   = r_err;
  assign cnt_ok    = r_cnt_ok;
  assign cnt_err   = r_cnt_err;

endmodule
